// File: rtl/mux_arb_n_pkg.sv
// Shared defaults, mode encoding and width helper for the mux_arb_n selector.
package mux_arb_n_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 4;
    localparam int unsigned DEFAULT_CHANNELS = 8;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n items, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// Rotating-priority picker: first set req bit at or after base, wrapping around.
module mux_arb_n_rr_pick
    import mux_arb_n_pkg::*;
#(
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    base,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    idx
);

    always_comb begin
        logic             found;
        logic [SEL_W-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cand = SEL_W'((32'(base) + k) % CHANNELS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// Registered N-channel selector with fixed-select or round-robin arbitration and
// valid/ready handshakes on both sides.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rr_en,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    words [CHANNELS];
    logic [CHANNELS-1:0] fixed_req;
    logic [CHANNELS-1:0] pick_req;
    logic [CHANNELS-1:0] pick_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    pick_base;
    logic [SEL_W-1:0]    pick_idx;
    logic                load_en;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // A sel code outside the channel range matches no bit and so never grants.
    for (genvar g = 0; g < CHANNELS; g++) begin : gen_chan
        assign words[g]     = in_data[g*WIDTH +: WIDTH];
        assign fixed_req[g] = in_valid[g] & (sel == SEL_W'(g));
    end

    assign pick_req  = (rr_en == MODE_FIXED) ? fixed_req : in_valid;
    assign pick_base = (rr_en == MODE_RR) ? ptr_q : '0;

    mux_arb_n_rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_pick (
        .req   (pick_req),
        .base  (pick_base),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign load_en  = !out_valid_q || out_ready;
    assign grant    = (load_en && !reset) ? pick_grant : '0;
    assign in_ready = grant;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (|grant) begin
            out_valid_d = 1'b1;
            out_data_d  = words[pick_idx];
            out_ch_d    = pick_idx;
            if (rr_en == MODE_RR) begin
                ptr_d = (32'(pick_idx) == CHANNELS - 1) ? '0 : pick_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
